// File: rtl/ks_adder_pkg.sv
// Shared definitions for the Kogge-Stone adder family: word width, the
// multi-precision sequencer state type and a ceiling-log2 helper.
package ks_adder_pkg;

    localparam int unsigned WORD_W = 64;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/ks_adder_64.sv
// 64-bit Kogge-Stone parallel-prefix adder with carry-in and carry-out.
module ks_adder_64
    import ks_adder_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic              cin,
    output logic [WORD_W-1:0] sum,
    output logic              cout
);

    localparam int unsigned LVLS = clog2(WORD_W);

    logic [WORD_W-1:0] p;
    logic [WORD_W-1:0] gk [0:LVLS];
    logic [WORD_W-1:0] pk [0:LVLS];

    assign p = a ^ b;

    // Carry-in folded into bit 0's generate, so prefix output i is the carry out of bit i.
    assign gk[0] = (a & b) | {{(WORD_W-1){1'b0}}, p[0] & cin};
    assign pk[0] = p;

    for (genvar l = 0; l < LVLS; l++) begin : g_lvl
        localparam int unsigned D = 1 << l;
        assign gk[l+1] = gk[l] | (pk[l] & (gk[l] << D));
        assign pk[l+1] = pk[l] & ~(~pk[l] << D);
    end

    assign sum  = p ^ {gk[LVLS][WORD_W-2:0], cin};
    assign cout = gk[LVLS][WORD_W-1];

endmodule

// File: rtl/ks_mp_adder_seq.sv
// Multi-precision add/subtract: streams NWORDS words LSW-first through one
// ks_adder_64, rippling the carry through a register between words.
module ks_mp_adder_seq #(
    parameter int unsigned WORD_W = ks_adder_pkg::WORD_W,
    parameter int unsigned NWORDS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WORD_W*NWORDS-1:0] in_a,
    input  logic [WORD_W*NWORDS-1:0] in_b,
    input  logic                     in_cin,
    input  logic                     in_sub,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WORD_W*NWORDS-1:0] out_sum,
    output logic                     out_cout,
    output logic                     out_ovf
);

    localparam int unsigned TW = WORD_W * NWORDS;

    if (WORD_W != ks_adder_pkg::WORD_W) begin : g_bad_word_w
        $error("ks_mp_adder_seq: WORD_W must equal the ks_adder_64 width");
    end
    if (NWORDS < 2 || NWORDS > 16) begin : g_bad_nwords
        $error("ks_mp_adder_seq: NWORDS must be in 2..16");
    end

    ks_adder_pkg::state_t state_q, state_d;

    logic [TW-1:0]     a_q, b_q, sum_q;
    logic              carry_q;
    logic [NWORDS-1:0] word_q;
    logic              cout_q, ovf_q;
    logic              last_word;
    logic [WORD_W-1:0] add_sum;
    logic              add_cout;

    // One-hot word position; all-zero outside RUN, so the top bit marks the final word.
    assign last_word = word_q[NWORDS-1];

    ks_adder_64 u_add (
        .a    (a_q[WORD_W-1:0]),
        .b    (b_q[WORD_W-1:0]),
        .cin  (carry_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ks_adder_pkg::S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ks_adder_pkg::S_IDLE: if (in_valid)  state_d = ks_adder_pkg::S_RUN;
            ks_adder_pkg::S_RUN:  if (last_word) state_d = ks_adder_pkg::S_DONE;
            ks_adder_pkg::S_DONE: if (out_ready) state_d = ks_adder_pkg::S_IDLE;
            default:                             state_d = ks_adder_pkg::S_IDLE;
        endcase
    end

    assign in_ready  = (state_q == ks_adder_pkg::S_IDLE);
    assign out_valid = (state_q == ks_adder_pkg::S_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            word_q  <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (state_q == ks_adder_pkg::S_IDLE) begin
            if (in_valid) begin
                a_q     <= in_a;
                b_q     <= in_sub ? ~in_b : in_b;
                carry_q <= in_sub | in_cin;
                word_q  <= {{(NWORDS-1){1'b0}}, 1'b1};
            end
        end else if (state_q == ks_adder_pkg::S_RUN) begin
            // Operands shift down so word 0 always feeds the adder; sum fills from the top.
            a_q     <= a_q >> WORD_W;
            b_q     <= b_q >> WORD_W;
            sum_q   <= {add_sum, sum_q[TW-1:WORD_W]};
            carry_q <= add_cout;
            word_q  <= word_q << 1;
            if (last_word) begin
                cout_q <= add_cout;
                ovf_q  <= (a_q[WORD_W-1] == b_q[WORD_W-1]) &&
                          (add_sum[WORD_W-1] != a_q[WORD_W-1]);
            end
        end
    end

    assign out_sum  = sum_q;
    assign out_cout = cout_q;
    assign out_ovf  = ovf_q;

endmodule
